rst_seq_gen: RTL
================

Name: rst_seq_gen

Overview:
Parametrised reset sequencer that replaces the single-output, lock-driven reset counter used in the SASEBO chip top-level.
- Waits for a synchronised PLL/DCM lock indication, then holds all resets for a programmable time.
- Releases N_OUT reset domains in staggered order: clock infrastructure, then the local-bus interface, then the crypto core.
- Supports software-requested re-reset and lock-loss recovery, and counts lock-loss events for debug (LED/status register).

Parameters:
- N_OUT, 3, number of staged reset outputs (>=1).
- CNT_W, 16, width of the shared hold/gap counter; must hold max(HOLD_CYC, SW_HOLD, STAGE_GAP).
- HOLD_CYC, 65535, cycles all resets stay asserted after lock is seen (>=1).
- SW_HOLD, 256, cycles all resets stay asserted after a software request (>=1).
- STAGE_GAP, 16, cycles between consecutive output releases (>=1).
- SYNC_STAGES, 2, flops in the `locked` synchroniser (>=2).

Ports:
- clk  in  1  system clock; single domain.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  asynchronous lock indication; high = clock stable.
- sw_rst_req  in  1  single-cycle software reset request, synchronous to clk.
- rst_out  out  N_OUT  active-high domain resets; bit 0 is released first.
- done  out  1  high when every rst_out bit is deasserted (state RUN).
- busy  out  1  high in HOLD, SW or RELEASE.
- loss_cnt  out  8  saturating count of lock-loss events.

Behaviour:
- Reset is synchronous and active-high. While rst=1, at each edge:
  - rst_out = all ones, done = 0, busy = 0, loss_cnt = 0.
  - state = WAIT, counter = 0, stage index = 0, synchroniser flops = 0.
- Synchroniser: `locked` passes through SYNC_STAGES flops to give locked_s. Only locked_s is used internally.
- Priority at any edge: rst > locked_s==0 > sw_rst_req > normal sequencing.
- WAIT: all rst_out asserted. When locked_s==1, go to HOLD with counter = 0. sw_rst_req is ignored.
- HOLD: counter increments each cycle. At the edge where counter==HOLD_CYC-1, go to RELEASE and clear rst_out[0] on that same edge. This release edge is the HOLD entry edge + HOLD_CYC. sw_rst_req is ignored.
- SW: entered from RUN or RELEASE on sw_rst_req.
  - All rst_out are re-asserted on the entry edge; counter = 0.
  - Behaves like HOLD with SW_HOLD in place of HOLD_CYC. rst_out[0] clears at the entry edge + SW_HOLD.
  - A further sw_rst_req while in SW is ignored; the counter is not restarted.
- RELEASE:
  - rst_out[i] clears STAGE_GAP edges after rst_out[i-1]; the counter counts the gap and reloads to 0 at each release.
  - On the edge that clears rst_out[N_OUT-1], go to RUN and set done=1. With N_OUT=1, that is the same edge that clears rst_out[0].
  - sw_rst_req goes to SW.
- RUN: rst_out = 0, done = 1, busy = 0. sw_rst_req goes to SW.
- Lock loss: locked_s==0 in HOLD, SW, RELEASE or RUN causes the following on the next edge:
  - State goes to WAIT; all rst_out are asserted; done = 0; counter = 0.
  - loss_cnt increments, saturating at 255.
  - locked_s==0 while already in WAIT does not count.
- Released outputs never re-assert individually; any re-reset asserts all bits together.
- Outputs are registered, with no combinational path from inputs to outputs.
- busy = (state in {HOLD, SW, RELEASE}), registered.

Test Plan (bench params: N_OUT=3, HOLD_CYC=8, SW_HOLD=5, STAGE_GAP=4, SYNC_STAGES=2):
1. Release rst with locked=1, first edge = E0.
   - locked_s=1 after E1; HOLD entered at E2.
   - rst_out[0] clears at E10, rst_out[1] at E14, rst_out[2] at E18.
   - done=1 at E18; loss_cnt=0.
2. In RUN, drop locked, sampled at edge k.
   - locked_s=0 after k+1; rst_out=3'b111, done=0, state WAIT after k+2; loss_cnt=1.
   - Restore locked: full 8-cycle HOLD, then staged release repeats.
3. In RUN, pulse sw_rst_req at edge j.
   - rst_out=3'b111 after j; rst_out[0] clears at j+5, [1] at j+9, [2] at j+13.
   - loss_cnt unchanged.
4. Pulse sw_rst_req after rst_out[0] released but before rst_out[1] (mid-RELEASE).
   - rst_out=3'b111 next edge; SW sequence restarts from 0.
   - A second request inside SW does not extend the hold.
5. Drop locked for 1 cycle mid-HOLD (counter=4).
   - State WAIT, counter=0, loss_cnt+1.
   - After relock, release timing is measured from the new HOLD entry (full 8 cycles).
6. Apply 300 lock-loss events, then rst mid-RELEASE.
   - loss_cnt reads 255 before the reset.
   - After the rst edge: loss_cnt=0, rst_out=3'b111, done=0, busy=0.

Source files
------------

// File: rtl/rst_seq_gen_if.sv
// Status/control bundle for the reset sequencer: lock and software request in,
// staged resets and debug status out.
interface rst_seq_gen_if #(
  parameter int unsigned N_OUT = 3
);
  logic             locked;
  logic             sw_rst_req;
  logic [N_OUT-1:0] rst_out;
  logic             done;
  logic             busy;
  logic [7:0]       loss_cnt;

  // Board/system side: drives lock and requests, observes resets.
  modport master (
    output locked, sw_rst_req,
    input  rst_out, done, busy, loss_cnt
  );

  // Sequencer side.
  modport slave (
    input  locked, sw_rst_req,
    output rst_out, done, busy, loss_cnt
  );
endinterface

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: waits for a synchronised lock, holds all resets, then
// releases the domains one by one. Handles software re-reset and lock loss.
module rst_seq_gen #(
  parameter int unsigned N_OUT       = 3,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned HOLD_CYC    = 65535,
  parameter int unsigned SW_HOLD     = 256,
  parameter int unsigned STAGE_GAP   = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic         clk,
  input logic         rst,
  rst_seq_gen_if.slave bus
);

  localparam int unsigned StW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  localparam logic [CNT_W-1:0] HoldLast  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] SwLast    = CNT_W'(SW_HOLD - 1);
  localparam logic [CNT_W-1:0] GapLast   = CNT_W'(STAGE_GAP - 1);
  localparam logic [StW-1:0]   StageLast = StW'(N_OUT - 1);

  typedef enum logic [2:0] {
    StWait,
    StHold,
    StSw,
    StRelease,
    StRun
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [StW-1:0]         stage_q, stage_d;  // index of the next output to release
  logic [N_OUT-1:0]       rst_out_q, rst_out_d;
  logic [7:0]             loss_q, loss_d;
  logic                   done_q, busy_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Two-or-more flop synchroniser for the asynchronous lock input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], bus.locked};
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StWait;
      cnt_q     <= '0;
      stage_q   <= '0;
      rst_out_q <= '1;
      loss_q    <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      stage_q   <= stage_d;
      rst_out_q <= rst_out_d;
      loss_q    <= loss_d;
      done_q    <= (state_d == StRun);
      busy_q    <= (state_d == StHold) || (state_d == StSw) || (state_d == StRelease);
    end
  end

  // Next-state logic: lock loss beats software request beats normal sequencing.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    loss_d    = loss_q;

    if (state_q != StWait && !locked_s) begin
      state_d   = StWait;
      rst_out_d = '1;
      cnt_d     = '0;
      stage_d   = '0;
      if (loss_q != 8'hff) loss_d = loss_q + 8'd1;
    end else begin
      unique case (state_q)
        StWait: begin
          rst_out_d = '1;
          stage_d   = '0;
          if (locked_s) begin
            state_d = StHold;
            cnt_d   = '0;
          end
        end
        StHold, StSw: begin
          // Requests during either hold are ignored so the hold is never extended.
          if (cnt_q == ((state_q == StHold) ? HoldLast : SwLast)) begin
            rst_out_d[0] = 1'b0;
            cnt_d        = '0;
            if (N_OUT == 1) begin
              state_d = StRun;
            end else begin
              state_d = StRelease;
              stage_d = StW'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StRelease: begin
          if (bus.sw_rst_req) begin
            state_d   = StSw;
            rst_out_d = '1;
            cnt_d     = '0;
            stage_d   = '0;
          end else if (cnt_q == GapLast) begin
            rst_out_d[stage_q] = 1'b0;
            cnt_d              = '0;
            if (stage_q == StageLast) begin
              state_d = StRun;
            end else begin
              stage_d = stage_q + StW'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StRun: begin
          rst_out_d = '0;
          if (bus.sw_rst_req) begin
            state_d   = StSw;
            rst_out_d = '1;
            cnt_d     = '0;
            stage_d   = '0;
          end
        end
        default: begin
          state_d   = StWait;
          rst_out_d = '1;
          cnt_d     = '0;
          stage_d   = '0;
        end
      endcase
    end
  end

  assign bus.rst_out  = rst_out_q;
  assign bus.done     = done_q;
  assign bus.busy     = busy_q;
  assign bus.loss_cnt = loss_q;

endmodule
